// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  // Requester 0 gets first priority out of reset.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [N_REQ-1:0] sel2gnt(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between requesters, the arbiter and the consumer.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] in;
  logic             ack;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic             out;

  modport master (
    output req, in, ack,
    input  gnt, sel, out_valid, out
  );

  modport slave (
    input  req, in, ack,
    output gnt, sel, out_valid, out
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick8.sv
// Rotating-priority scan: first set req bit strictly after 'last', wrapping back to 'last' itself.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// 8-way round-robin arbiter driving a 1-bit data mux; back-to-back tenures without bubbles.
// Define MUX_ARB_MAXHOLD_EN to force rotation after MAX_HOLD un-acked grant cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arbiter_if.slave    bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be within 1..15");
  end

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;

  logic             granted;
  logic             out_valid_c;
  logic             handshake;
  logic             withdraw;
  logic             force_rot;
  logic             tenure_end;
  logic [SEL_W-1:0] pick_last;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  assign granted     = (state == GRANT);
  assign out_valid_c = granted && bus.req[sel_q];
  assign handshake   = out_valid_c && bus.ack;
  assign withdraw    = granted && !bus.req[sel_q];

`ifdef MUX_ARB_MAXHOLD_EN
  logic [3:0] hold_q;

  // Rotation is only forced when someone else is actually waiting.
  assign force_rot = granted && (hold_q == 4'(MAX_HOLD - 1)) && (|(bus.req & ~gnt_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!granted || tenure_end) begin
      hold_q <= '0;
    end else if (hold_q != 4'(MAX_HOLD - 1)) begin
      hold_q <= hold_q + 4'd1;
    end
  end
`else
  assign force_rot = 1'b0;
`endif

  assign tenure_end = handshake || withdraw || force_rot;

  // At a tenure end the just-served index becomes the new 'last' for the same-edge pick.
  assign pick_last = granted ? sel_q : last_q;

  rr_pick8 u_pick (
    .req  (bus.req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      last_q <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= GRANT;
            sel_q <= pick_idx;
            gnt_q <= sel2gnt(pick_idx);
          end
        end
        GRANT: begin
          if (tenure_end) begin
            last_q <= sel_q;
            if (pick_any) begin
              sel_q <= pick_idx;
              gnt_q <= sel2gnt(pick_idx);
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out       = out_valid_c & bus.in[sel_q];

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum cycles a grant is held without ack when MUX_ARB_MAXHOLD_EN is defined (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  8  per-requester request; req[i] belongs to requester i.
REQ-005 Port: in  input  8  per-requester data bit; in[i] belongs to requester i.
REQ-006 Port: ack  input  1  consumer accepts the current output beat.
REQ-007 Port: gnt  output  8  one-hot grant, registered.
REQ-008 Port: sel  output  3  index of the granted requester, registered, drives the data mux.
REQ-009 Port: out_valid  output  1  output beat valid.
REQ-010 Port: out  output  1  selected data bit, in[sel], gated by out_valid.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE and hold gnt=0 and out_valid=0.
REQ-013 In IDLE with req!=0, the winner SHALL be the first set bit scanning upward from (last+1) mod 8 with wrap; gnt, sel and the GRANT state SHALL update at the next edge (1-cycle request-to-grant latency).
REQ-014 In GRANT, out_valid SHALL equal req[sel], combinationally.
REQ-015 out SHALL equal in[sel] when out_valid=1, else 0.
REQ-016 A tenure SHALL end at an edge where (out_valid && ack), or where req[sel]=0 (requester withdrew); at that edge last<=sel.
REQ-017 At a tenure end, if any req bit is set, the next winner SHALL be picked with the updated last and granted at the same edge (back-to-back, no bubble); otherwise the state SHALL return to IDLE with gnt=0.
REQ-018 The just-served requester SHALL win again only if no other req bit is set.
REQ-019 ack while out_valid=0 SHALL be ignored.
REQ-020 A req bit rising mid-tenure SHALL not preempt the current grant.
REQ-021 gnt SHALL always be zero or one-hot and consistent with sel (gnt == 1<<sel in GRANT).

Reset
REQ-022 While rst=1: state=IDLE, gnt=0, sel=0, out_valid=0, out=0, last=7 (requester 0 has first priority), hold counter=0.
REQ-023 Reset asserted mid-tenure SHALL drop the grant immediately (asynchronously) with no completing beat.

Configuration
REQ-024 With MUX_ARB_MAXHOLD_EN defined, a hold counter SHALL count GRANT cycles without a handshake and clear on every tenure start; when it reaches MAX_HOLD and another req bit is set, the tenure SHALL end as in REQ-016/017 (forced rotation).
REQ-025 Without MUX_ARB_MAXHOLD_EN, no hold counter SHALL exist and a tenure SHALL end only per REQ-016; MAX_HOLD SHALL be unused.

Structure
REQ-026 Package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3, and the state type {IDLE, GRANT}.
REQ-027 Sub-module rr_pick8 (combinational: req[7:0], last[2:0] -> any, idx[2:0]) SHALL implement the rotating priority scan; it is used for both the IDLE and the tenure-end decisions.

Verification
REQ-028 After reset, req=8'h01, ack=1 -> gnt=8'h01 and sel=0 at edge 1; out_valid=1, out=in[0]; return to IDLE after one beat once req drops.
REQ-029 req=8'hFF held, ack=1 every cycle -> sel sequence 0,1,2,...,7,0 with one beat per cycle and no bubbles.
REQ-030 After serving sel=5, req=8'h21 -> next sel=0 (wrap past 6,7); with req=8'h20 alone -> sel=5 again.
REQ-031 While sel=3 granted and ack=0, req[3] drops -> out_valid=0 in that cycle, last=3, rearbitration at that edge.
REQ-032 With MUX_ARB_MAXHOLD_EN, MAX_HOLD=4, req=8'h03, ack=0 -> sel=0 for 4 cycles, then sel=1; without the macro, sel stays 0 indefinitely.
REQ-033 Assert rst mid-tenure with sel=6 -> gnt=0, out_valid=0 immediately; after release with req=8'h40 -> sel=6 granted one cycle later.
